irq_ctrl: RTL

Parametrised, memory-mapped interrupt controller for the 6502 core. Collects up to 16 external interrupt sources plus one non-maskable source, synchronises them, latches them by edge or level per source, and drives the core's active-low IRQ and NMI lines. Software clears edge-latched sources and reads the priority vector over the 8-bit CPU bus.

---
 rtl/irq_ctrl_pkg.sv | 52 +++++
 rtl/irq_ctrl_sync_edge.sv | 38 +++
 rtl/irq_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants and helpers for the 6502 interrupt controller.
// Register map, mode encodings and the priority-encoder helper live here.
package irq_ctrl_pkg;

    localparam int MAX_SRC = 16;

    localparam logic [2:0] OFF_PEND_L = 3'd0;
    localparam logic [2:0] OFF_PEND_H = 3'd1;
    localparam logic [2:0] OFF_EN_L   = 3'd2;
    localparam logic [2:0] OFF_EN_H   = 3'd3;
    localparam logic [2:0] OFF_MODE_L = 3'd4;
    localparam logic [2:0] OFF_MODE_H = 3'd5;
    localparam logic [2:0] OFF_VECTOR = 3'd6;
    localparam logic [2:0] OFF_CTRL   = 3'd7;

    localparam logic MODE_EDGE  = 1'b1;
    localparam logic MODE_LEVEL = 1'b0;

    localparam logic [7:0] VEC_NONE = 8'h80;

    localparam int CTRL_GIE_BIT = 0;
    localparam int CTRL_NMI_BIT = 7;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } prio_t;

    // Mask of implemented source bits for a controller with n sources.
    function automatic logic [MAX_SRC-1:0] src_mask(input int n);
        logic [MAX_SRC-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Lowest set bit wins; scanning downward lets the lowest index overwrite.
    function automatic prio_t lowest_set(input logic [MAX_SRC-1:0] v);
        prio_t r;
        r = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                r.valid = 1'b1;
                r.idx   = i[3:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_ctrl_sync_edge.sv
// Two-flop synchroniser with rising-edge detect for one asynchronous source.
// Module name is irq_sync_edge; one instance per interrupt input.
module irq_sync_edge (
    input  logic clk,
    input  logic res,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic       s1_q;
    logic       s2_q;
    logic       prev_q;
    logic [1:0] warm_q;

    // For the first two edges after reset the previous-value flop follows
    // stage 1, so it already agrees with stage 2 when detection starts and a
    // source that was high through reset is not mistaken for a new edge.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            warm_q <= 2'b00;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge value of its neighbour, forming a true shift chain.
            s1_q   <= d_i;
            s2_q   <= s1_q;
            prev_q <= warm_q[1] ? s2_q : s1_q;
            warm_q <= {warm_q[0], 1'b1};
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: up to 16 maskable sources plus NMI,
// edge/level latching, priority vector and registered active-low IRQ/NMI.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int          N_SRC     = 8,
    parameter logic [15:0] BASE_ADDR = 16'hFE00
) (
    input  logic             clk,
    input  logic             res,
    input  logic [15:0]      add_bus,
    input  logic [7:0]       d_in,
    output logic [7:0]       d_out,
    input  logic             write_en,
    input  logic             rdy,
    output logic             sel,
    input  logic [N_SRC-1:0] src,
    input  logic             nmi_src,
    output logic             IRQ,
    output logic             NMI
);

    localparam logic [MAX_SRC-1:0] VALID = src_mask(N_SRC);

    logic [2:0]         off;
    logic               wr;
    logic               rd_ack;

    logic [MAX_SRC-1:0] en_q, en_d;
    logic [MAX_SRC-1:0] mode_q, mode_d;
    logic [MAX_SRC-1:0] pend_q, pend_d;
    logic               gie_q, gie_d;
    logic               nmi_pend_q, nmi_pend_d;
    logic               irq_n_q, nmi_n_q;

    logic [MAX_SRC-1:0] src_lvl;
    logic [MAX_SRC-1:0] src_rise;
    logic [MAX_SRC-1:0] clr;
    logic [MAX_SRC-1:0] pend_en;
    logic               nmi_lvl_unused;
    logic               nmi_rise;
    logic               nmi_clr;
    prio_t              prio;

    assign sel = (add_bus[15:3] == BASE_ADDR[15:3]);
    assign off = add_bus[2:0];
    assign wr  = sel & write_en;

    // Unimplemented source slots are tied off so they can never pend.
    for (genvar i = 0; i < MAX_SRC; i++) begin : g_src
        if (i < N_SRC) begin : g_on
            irq_sync_edge u_sync (
                .clk     (clk),
                .res     (res),
                .d_i     (src[i]),
                .level_o (src_lvl[i]),
                .rise_o  (src_rise[i])
            );
        end else begin : g_off
            assign src_lvl[i]  = 1'b0;
            assign src_rise[i] = 1'b0;
        end
    end

    irq_sync_edge u_nmi_sync (
        .clk     (clk),
        .res     (res),
        .d_i     (nmi_src),
        .level_o (nmi_lvl_unused),
        .rise_o  (nmi_rise)
    );

    assign pend_en = pend_q & en_q;
    assign prio    = lowest_set(pend_en);
    assign rd_ack  = sel & ~write_en & rdy & (off == OFF_VECTOR) & prio.valid;
    assign nmi_clr = wr & (off == OFF_CTRL) & d_in[CTRL_NMI_BIT];

    // Clear requests: write-1-to-clear on PEND plus the VECTOR read acknowledge.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise an unassigned path would infer a latch.
        clr = '0;
        if (wr && off == OFF_PEND_L) clr[7:0]  = d_in;
        if (wr && off == OFF_PEND_H) clr[15:8] = d_in;
        if (rd_ack) clr[prio.idx] = 1'b1;
    end

    always_comb begin
        en_d   = en_q;
        mode_d = mode_q;
        gie_d  = gie_q;
        if (wr) begin
            case (off)
                OFF_EN_L:   en_d[7:0]    = d_in;
                OFF_EN_H:   en_d[15:8]   = d_in;
                OFF_MODE_L: mode_d[7:0]  = d_in;
                OFF_MODE_H: mode_d[15:8] = d_in;
                OFF_CTRL:   gie_d        = d_in[CTRL_GIE_BIT];
                default:    ;
            endcase
        end
        en_d   = en_d & VALID;
        mode_d = mode_d & VALID;
    end

    // A new edge is OR-ed in after the clear, so a same-edge set always wins.
    always_comb begin
        pend_d = '0;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (mode_q[i] == MODE_LEVEL) begin
                pend_d[i] = src_lvl[i];
            end else if (mode_q[i] == MODE_EDGE) begin
                pend_d[i] = src_rise[i] | (pend_q[i] & ~clr[i]);
            end
        end
        pend_d = pend_d & VALID;
    end

    assign nmi_pend_d = nmi_rise | (nmi_pend_q & ~nmi_clr);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            en_q       <= '0;
            mode_q     <= '0;
            pend_q     <= '0;
            gie_q      <= 1'b0;
            nmi_pend_q <= 1'b0;
            irq_n_q    <= 1'b1;
            nmi_n_q    <= 1'b1;
        end else begin
            en_q       <= en_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            gie_q      <= gie_d;
            nmi_pend_q <= nmi_pend_d;
            irq_n_q    <= ~(gie_q & |pend_en);
            nmi_n_q    <= ~nmi_pend_q;
        end
    end

    assign IRQ = irq_n_q;
    assign NMI = nmi_n_q;

    always_comb begin
        d_out = '0;
        if (sel) begin
            case (off)
                OFF_PEND_L: d_out = pend_q[7:0];
                OFF_PEND_H: d_out = pend_q[15:8];
                OFF_EN_L:   d_out = en_q[7:0];
                OFF_EN_H:   d_out = en_q[15:8];
                OFF_MODE_L: d_out = mode_q[7:0];
                OFF_MODE_H: d_out = mode_q[15:8];
                OFF_VECTOR: d_out = prio.valid ? {4'b0000, prio.idx} : VEC_NONE;
                OFF_CTRL: begin
                    d_out[CTRL_NMI_BIT] = nmi_pend_q;
                    d_out[CTRL_GIE_BIT] = gie_q;
                end
                default:    d_out = '0;
            endcase
        end
    end

endmodule
